aes_round_sequencer: RTL and testbench
======================================

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, number of operation pulses issued per block (0..15).
REQ-002 SHALL have parameter OP_CYCLES, default 1, cycles mem_operation is held high per round (1..4).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  begin one block; sampled only in IDLE.
REQ-006 SHALL have ports in_valid input 1, in_data input 8, in_ready output 1  plaintext byte stream, byte 0 first.
REQ-007 SHALL have ports out_valid output 1, out_data output 8, out_ready input 1  result byte stream, byte 0 first.
REQ-008 SHALL have ports busy output 1 (not IDLE) and done output 1 (one-cycle completion pulse).
REQ-009 SHALL have memory-side ports mem_cs, mem_RW (read=1, write=0) and mem_operation (output 1 each), mem_address output 4, mem_DataIN output 8, and mem_DataOut input 8.

Function
REQ-010 SHALL implement states IDLE, LOAD, OP, OP_GAP, RD_ADDR, RD_DATA, DONE, plus a 4-bit byte index and a 4-bit round counter.
REQ-011 IDLE: start=1 SHALL move to LOAD, clearing index and round counter; start in any other state SHALL be ignored.
REQ-012 LOAD: in_ready=1; on in_valid&in_ready, mem_cs=1, mem_RW=0, mem_operation=0, mem_address=index, mem_DataIN=in_data in the same cycle, and index increments.
REQ-013 LOAD: on the handshake with index=15, index SHALL wrap to 0 and go to OP (NUM_ROUNDS>0) or RD_ADDR (NUM_ROUNDS=0); without in_valid, all mem_* strobes stay 0.
REQ-014 OP: mem_cs=1, mem_operation=1, mem_RW=0 for exactly OP_CYCLES consecutive cycles, then OP_GAP.
REQ-015 OP_GAP: mem_cs=0, mem_operation=0 for one cycle; round counter increments; next OP if counter<NUM_ROUNDS, else RD_ADDR.
REQ-016 RD_ADDR: mem_cs=1, mem_RW=1, mem_operation=0, mem_address=index for one cycle, then RD_DATA.
REQ-017 RD_DATA: mem_cs=0; on entry out_data SHALL register mem_DataOut and out_valid=1, both held stable until out_ready=1.
REQ-018 RD_DATA: on out_valid&out_ready, index increments and state returns to RD_ADDR, or goes to DONE when index was 15.
REQ-019 DONE: done=1 for exactly one cycle, out_valid=0, then IDLE.
REQ-020 in_ready SHALL be 0 outside LOAD; in_valid outside LOAD SHALL be ignored and cause no memory access.
REQ-021 mem_cs, mem_operation and mem_RW SHALL never form a write (cs=1, RW=0, operation=0) outside LOAD handshake cycles.
REQ-022 With no stalls, start-to-done SHALL be 1 + 16 + NUM_ROUNDS*(OP_CYCLES+1) + 32 + 1 cycles.
REQ-023 Round counter and index SHALL be 4-bit, wrapping modulo 16, with no overflow state.

Reset
REQ-024 With RST=1 at a clock edge: state=IDLE, index=0, round counter=0, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, mem_cs=0, mem_RW=1, mem_operation=0, mem_address=0, mem_DataIN=0.
REQ-025 RST SHALL take precedence over start and all handshakes; reset in any state, including mid-LOAD or mid-OP, aborts the block with no further memory access; memory contents are then undefined.

Verification
REQ-026 Load bytes 00..0F, NUM_ROUNDS=0 -> 16 writes to addresses 0..15, out stream 00..0F, done pulse at cycle 50 after start.
REQ-027 NUM_ROUNDS=10, OP_CYCLES=1, no stalls -> exactly 10 single-cycle mem_operation pulses, each followed by a cs=0 cycle, done at cycle 70.
REQ-028 in_valid toggled 1/0 every cycle during LOAD -> only handshake cycles write, addresses strictly 0..15 in order.
REQ-029 out_ready held 0 for 5 cycles on byte 3 -> out_data stable and out_valid=1 throughout, no extra mem read issued.
REQ-030 RST=1 for one cycle during the 4th OP pulse -> next cycle all outputs at REQ-024 values; new start completes a full block correctly.
REQ-031 start pulsed during READ and in_valid asserted in IDLE -> no state change, no memory access.

Source files
------------

// File: rtl/aes_round_sequencer_if.sv
// Byte-stream, control and memory-side signals of the AES round sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface aes_round_sequencer_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic       mem_cs;
  logic       mem_RW;
  logic       mem_operation;
  logic [3:0] mem_address;
  logic [7:0] mem_DataIN;
  logic [7:0] mem_DataOut;

  modport master (
    input  start, in_valid, in_data, out_ready, mem_DataOut,
    output busy, done, in_ready, out_valid, out_data,
           mem_cs, mem_RW, mem_operation, mem_address, mem_DataIN
  );

  modport slave (
    output start, in_valid, in_data, out_ready, mem_DataOut,
    input  busy, done, in_ready, out_valid, out_data,
           mem_cs, mem_RW, mem_operation, mem_address, mem_DataIN
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Drives one AES block through an external round engine: 16 byte writes,
// NUM_ROUNDS operation pulses, then 16 byte reads streamed out.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int OP_CYCLES  = 1
) (
  input logic                   CLK,
  input logic                   RST,
  aes_round_sequencer_if.master bus
);

  localparam logic [3:0] ROUNDS  = 4'(NUM_ROUNDS);
  localparam logic [1:0] OP_LAST = 2'(OP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, OP, OP_GAP, RD_ADDR, RD_DATA, DONE
  } state_t;

  state_t     state, state_n;
  logic [3:0] index, index_n;
  logic [3:0] round_cnt, round_n;
  logic [1:0] op_cnt, op_n;
  logic [7:0] out_data_q;

  logic       in_ready_c, out_valid_c, done_c;
  logic       mem_cs_c, mem_rw_c, mem_op_c;
  logic [7:0] mem_din_c;

  // NOTE: every output and next-state value gets a default before the case
  // statement, so no path through this block can leave a latch behind.
  always_comb begin
    state_n     = state;
    index_n     = index;
    round_n     = round_cnt;
    op_n        = op_cnt;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    done_c      = 1'b0;
    mem_cs_c    = 1'b0;
    mem_rw_c    = 1'b1;
    mem_op_c    = 1'b0;
    mem_din_c   = 8'h00;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = LOAD;
          index_n = 4'd0;
          round_n = 4'd0;
        end
      end
      LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          mem_cs_c  = 1'b1;
          mem_rw_c  = 1'b0;
          mem_din_c = bus.in_data;
          index_n   = index + 4'd1;
          op_n      = 2'd0;
          if (index == 4'd15) state_n = (ROUNDS != 4'd0) ? OP : RD_ADDR;
        end
      end
      OP: begin
        mem_cs_c = 1'b1;
        mem_rw_c = 1'b0;
        mem_op_c = 1'b1;
        if (op_cnt == OP_LAST) begin
          op_n    = 2'd0;
          state_n = OP_GAP;
        end else begin
          op_n = op_cnt + 2'd1;
        end
      end
      OP_GAP: begin
        round_n = round_cnt + 4'd1;
        state_n = (round_n < ROUNDS) ? OP : RD_ADDR;
      end
      RD_ADDR: begin
        mem_cs_c = 1'b1;
        state_n  = RD_DATA;
      end
      RD_DATA: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          index_n = index + 4'd1;
          state_n = (index == 4'd15) ? DONE : RD_ADDR;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      index      <= 4'd0;
      round_cnt  <= 4'd0;
      op_cnt     <= 2'd0;
      out_data_q <= 8'h00;
    end else begin
      state     <= state_n;
      index     <= index_n;
      round_cnt <= round_n;
      op_cnt    <= op_n;
      // Read data is combinational from the memory while RD_ADDR presents the address.
      if (state == RD_ADDR) out_data_q <= bus.mem_DataOut;
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_c;
  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_data      = out_data_q;
  assign bus.mem_cs        = mem_cs_c;
  assign bus.mem_RW        = mem_rw_c;
  assign bus.mem_operation = mem_op_c;
  assign bus.mem_address   = index;
  assign bus.mem_DataIN    = mem_din_c;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: one instance with no rounds, one with
// ten single-cycle rounds, each backed by a behavioural 16-byte memory.
module tb_aes_round_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       sel;
  logic       start, in_valid, out_ready;
  logic [7:0] in_data;

  always #5 CLK = ~CLK;

  aes_round_sequencer_if if0 ();
  aes_round_sequencer_if if1 ();

  aes_round_sequencer #(.NUM_ROUNDS(0), .OP_CYCLES(1)) dut0 (.CLK(CLK), .RST(RST), .bus(if0));
  aes_round_sequencer #(.NUM_ROUNDS(10), .OP_CYCLES(1)) dut1 (.CLK(CLK), .RST(RST), .bus(if1));

  assign if0.start     = start & ~sel;
  assign if1.start     = start & sel;
  assign if0.in_valid  = in_valid & ~sel;
  assign if1.in_valid  = in_valid & sel;
  assign if0.in_data   = in_data;
  assign if1.in_data   = in_data;
  assign if0.out_ready = out_ready;
  assign if1.out_ready = out_ready;

  // Memory model: writes store a byte, each operation cycle adds 1 to every byte.
  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  assign if0.mem_DataOut = mem0[if0.mem_address];
  assign if1.mem_DataOut = mem1[if1.mem_address];

  always @(posedge CLK) begin
    if (if0.mem_cs && !if0.mem_RW && !if0.mem_operation) mem0[if0.mem_address] <= if0.mem_DataIN;
    else if (if0.mem_cs && if0.mem_operation) for (int i = 0; i < 16; i++) mem0[i] <= mem0[i] + 8'd1;
    if (if1.mem_cs && !if1.mem_RW && !if1.mem_operation) mem1[if1.mem_address] <= if1.mem_DataIN;
    else if (if1.mem_cs && if1.mem_operation) for (int i = 0; i < 16; i++) mem1[i] <= mem1[i] + 8'd1;
  end

  // Observed view of whichever instance is selected.
  logic       o_busy, o_done, o_in_ready, o_in_valid, o_out_valid;
  logic       o_cs, o_rw, o_op;
  logic [7:0] o_out_data, o_din;
  logic [3:0] o_addr;
  assign o_busy      = sel ? if1.busy          : if0.busy;
  assign o_done      = sel ? if1.done          : if0.done;
  assign o_in_ready  = sel ? if1.in_ready      : if0.in_ready;
  assign o_in_valid  = sel ? if1.in_valid      : if0.in_valid;
  assign o_out_valid = sel ? if1.out_valid     : if0.out_valid;
  assign o_out_data  = sel ? if1.out_data      : if0.out_data;
  assign o_cs        = sel ? if1.mem_cs        : if0.mem_cs;
  assign o_rw        = sel ? if1.mem_RW        : if0.mem_RW;
  assign o_op        = sel ? if1.mem_operation : if0.mem_operation;
  assign o_addr      = sel ? if1.mem_address   : if0.mem_address;
  assign o_din       = sel ? if1.mem_DataIN    : if0.mem_DataIN;

  int checks = 0;
  int errors = 0;

  // Bus monitor, sampled mid-cycle.
  int         ncyc = 0;
  int         wr_cnt, wr_bad, rd_cnt, op_cyc, op_rise, gap_bad, done_cnt, done_at, start_at;
  logic       prev_op;
  logic [7:0] out_q[$];

  always @(negedge CLK) begin
    ncyc++;
    if (o_cs && !o_rw && !o_op) begin
      if (!(o_in_ready && o_in_valid) || o_addr != wr_cnt[3:0]) wr_bad++;
      wr_cnt++;
    end
    if (o_cs && o_rw) rd_cnt++;
    if (o_op) begin
      op_cyc++;
      if (!prev_op) op_rise++;
      if (!o_cs || o_rw) gap_bad++;
    end
    if (prev_op && !o_op && o_cs) gap_bad++;
    if (o_out_valid && out_ready) out_q.push_back(o_out_data);
    if (o_done) begin
      done_cnt++;
      done_at = ncyc;
    end
    prev_op = o_op;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    wr_cnt = 0; wr_bad = 0; rd_cnt = 0; op_cyc = 0; op_rise = 0;
    gap_bad = 0; done_cnt = 0; done_at = 0; prev_op = 1'b0;
    out_q.delete();
  endtask

  task automatic start_block();
    clear_mon();
    start    = 1'b1;
    start_at = ncyc + 1;
    step();
    start = 1'b0;
  endtask

  task automatic load_bytes(input bit toggle, input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      if (toggle) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = base ^ 8'(i);
      step();
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic expect_reset_outputs(input string name);
    checks++;
    if ({o_busy, o_done, o_in_ready, o_out_valid, o_cs, o_rw, o_op} !== 7'b0000010) begin
      errors++;
      $display("FAIL %s ctrl: got busy/done/in_rdy/out_vld/cs/rw/op=%b required 0000010", name,
               {o_busy, o_done, o_in_ready, o_out_valid, o_cs, o_rw, o_op});
    end
    checks++;
    if ({o_out_data, o_addr, o_din} !== 20'h0) begin
      errors++;
      $display("FAIL %s data: got out_data=%h addr=%h din=%h required all zero", name,
               o_out_data, o_addr, o_din);
    end
  endtask

  task automatic run_block(input string name, input logic which, input logic [7:0] base,
                           input int rounds, input bit toggle, input int stall_byte,
                           input bit start_in_read, input int exp_len);
    bit         finished = 0;
    bit         stalled  = 0;
    bit         pulsed   = 0;
    logic [7:0] held;
    int         rd_before;
    sel = which;
    start_block();
    load_bytes(toggle, base);
    for (int k = 0; k < 400 && !finished; k++) begin
      start = start_in_read && !pulsed && out_q.size() == 5;
      if (start) pulsed = 1;
      if (stall_byte >= 0 && !stalled && o_out_valid && out_q.size() == stall_byte) begin
        stalled   = 1;
        out_ready = 1'b0;
        held      = o_out_data;
        rd_before = rd_cnt;
        for (int s = 0; s < 5; s++) begin
          checks++;
          if (o_out_valid !== 1'b1 || o_out_data !== held) begin
            errors++;
            $display("FAIL %s stall: got valid=%b data=%h required valid=1 data=%h",
                     name, o_out_valid, o_out_data, held);
          end
          step();
        end
        checks++;
        if (rd_cnt != rd_before) begin
          errors++;
          $display("FAIL %s stall_reads: got %0d reads during stall required 0", name, rd_cnt - rd_before);
        end
        out_ready = 1'b1;
      end
      step();
      start = 1'b0;
      if (done_cnt > 0) finished = 1;
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL %s timeout: got no done pulse required one", name);
    end
    step();
    step();
    checks++;
    if (done_cnt != 1 || done_at - start_at + 1 != exp_len) begin
      errors++;
      $display("FAIL %s latency: got %0d pulses at cycle %0d required 1 at cycle %0d",
               name, done_cnt, done_at - start_at + 1, exp_len);
    end
    checks++;
    if (wr_cnt != 16 || wr_bad != 0 || rd_cnt != 16) begin
      errors++;
      $display("FAIL %s mem: got writes=%0d bad=%0d reads=%0d required 16/0/16", name, wr_cnt, wr_bad, rd_cnt);
    end
    checks++;
    if (op_rise != rounds || op_cyc != rounds || gap_bad != 0) begin
      errors++;
      $display("FAIL %s ops: got pulses=%0d cycles=%0d gap_bad=%0d required %0d/%0d/0",
               name, op_rise, op_cyc, gap_bad, rounds, rounds);
    end
    checks++;
    if (out_q.size() != 16) begin
      errors++;
      $display("FAIL %s out_len: got %0d bytes required 16", name, out_q.size());
    end
    for (int i = 0; i < 16 && i < out_q.size(); i++) begin
      checks++;
      if (out_q[i] !== 8'((base ^ 8'(i)) + 8'(rounds))) begin
        errors++;
        $display("FAIL %s out[%0d]: got %h required %h", name, i, out_q[i], 8'((base ^ 8'(i)) + 8'(rounds)));
      end
    end
    checks++;
    if (o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_after: got busy=%b in_ready=%b required 0/0", name, o_busy, o_in_ready);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    RST = 1'b1;
    step();
    step();
    expect_reset_outputs("reset");
    RST = 1'b0;
    step();
  endtask

  task automatic test_idle_ignore();
    sel = 1'b0;
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 4; i++) step();
    in_valid = 1'b0;
    checks++;
    if (wr_cnt != 0 || rd_cnt != 0 || o_busy !== 1'b0 || o_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_in_valid: got writes=%0d reads=%0d busy=%b in_ready=%b required 0/0/0/0",
               wr_cnt, rd_cnt, o_busy, o_in_ready);
    end
  endtask

  task automatic test_no_rounds();     run_block("no_rounds", 1'b0, 8'h00, 0, 0, -1, 0, 50); endtask
  task automatic test_ten_rounds();    run_block("ten_rounds", 1'b1, 8'hF0, 10, 0, -1, 0, 70); endtask
  task automatic test_valid_toggle();  run_block("valid_toggle", 1'b0, 8'h3C, 0, 1, -1, 0, 66); endtask
  task automatic test_out_stall();     run_block("out_stall", 1'b0, 8'h80, 0, 0, 3, 0, 55); endtask
  task automatic test_start_in_read(); run_block("start_in_read", 1'b0, 8'h11, 0, 0, -1, 1, 50); endtask

  task automatic test_reset_mid_op();
    bit hit = 0;
    sel = 1'b1;
    start_block();
    load_bytes(0, 8'hC3);
    for (int k = 0; k < 100 && !hit; k++) begin
      if (o_op && op_rise == 3) hit = 1;
      else step();
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL mid_op_wait: got no 4th operation pulse required one");
    end
    RST = 1'b1;
    step();
    expect_reset_outputs("mid_op_reset");
    RST = 1'b0;
    clear_mon();
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (wr_cnt + rd_cnt + op_cyc != 0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_op_quiet: got %0d memory cycles busy=%b required 0/0", wr_cnt + rd_cnt + op_cyc, o_busy);
    end
    run_block("after_reset", 1'b1, 8'h5A, 10, 0, -1, 0, 70);
  endtask

  initial begin
    RST       = 1'b1;
    sel       = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b1;
    clear_mon();
    test_reset();
    test_idle_ignore();
    test_no_rounds();
    test_ten_rounds();
    test_valid_toggle();
    test_out_stall();
    test_start_in_read();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
